// File: rtl/mul_radix16_sequencer.sv
// Sequential unsigned 32x32->64 multiply-accumulate, one 4-bit multiplier digit per cycle.
// Exits early once the remaining multiplier digits are all zero.
`timescale 1ns/1ps
module mul_radix16_sequencer #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             acc_en,
    input  logic [2*W-1:0]   acc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   result,
    output logic             busy
);
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PP_W    = W + DIGIT_W;
    localparam int unsigned RES_W   = 2 * W;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [RES_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic               load;
    logic               step;
    logic               finish;
    logic               last;
    logic [PP_W-1:0]    pp;
    logic [RES_W-1:0]   acc_sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and datapath strobes
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        start_ready = (state == IDLE) && !rst;
        pp          = PP_W'(a) * PP_W'(b[DIGIT_W-1:0]);
        acc_sum     = acc + (RES_W'(pp) << {cnt, 2'b00});
        last        = (b[W-1:DIGIT_W] == '0) || (cnt == CNT_W'(7));
        case (state)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_next = CALC;
                    load       = 1'b1;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                if (res_valid && res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            if (load) begin
                a   <= op_a;
                b   <= op_b;
                acc <= acc_en ? acc_in : '0;
                cnt <= '0;
            end else if (step) begin
                acc <= acc_sum;
                b   <= b >> DIGIT_W;
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                result    <= acc_sum;
                res_valid <= 1'b1;
            end else if ((state == DONE) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_radix16_sequencer.sv
// Self-checking bench for mul_radix16_sequencer: directed vectors, backpressure,
// mid-operation reset and random back-to-back traffic against a scoreboard.
`timescale 1ns/1ps
module tb_mul_radix16_sequencer;
    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        acc_en = 1'b0;
    logic [63:0] acc_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [63:0] result;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    localparam int NV = 6;
    localparam logic [31:0] VA [NV] = '{32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                                        32'hFFFFFFFF, 32'hDEADBEEF, 32'h00000002};
    localparam logic [31:0] VB [NV] = '{32'hFFFFFFFF, 32'h00000003, 32'h00010000,
                                        32'hFFFFFFFF, 32'h00000000, 32'h00000003};
    localparam logic        VE [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [63:0] VI [NV] = '{64'd0, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF,
                                        64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF};
    localparam logic [63:0] VR [NV] = '{64'hFFFFFFFE00000001, 64'h00000000369D0368,
                                        64'h0000123456780000, 64'hFFFFFFFE00000000,
                                        64'h0123456789ABCDEF, 64'h0000000000000006};
    localparam int          VL [NV] = '{8, 1, 5, 8, 1, 1};

    mul_radix16_sequencer #(.W(32)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .acc_en(acc_en), .acc_in(acc_in),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width product plus addend; latency from highest nonzero nibble
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic en, input logic [63:0] ai);
        exp_t e;
        e.res = (en ? ai : 64'd0) + ({32'd0, a} * {32'd0, b});
        e.lat = 1;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] != 4'd0) e.lat = i + 1;
        end
        return e;
    endfunction

    // Stimulus only: accept one operation, wait for res_valid, optionally consume it
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic en,
                         input logic [63:0] ai, input bit consume,
                         output logic [63:0] res, output int lat,
                         output int acc_cyc, output bit to);
        int n;
        to = 1'b0; lat = 0; res = '0; acc_cyc = 0; n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            to = 1'b1;
        end else begin
            op_a = a; op_b = b; acc_en = en; acc_in = ai; start_valid = 1'b1;
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            acc_cyc = cyc;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk);
                #1;
                if (res_valid && lat == 0) begin
                    lat = i;
                    res = result;
                    break;
                end
            end
            if (lat == 0) to = 1'b1;
            else if (consume) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || result !== 64'd0 || busy !== 1'b0 || start_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: res_valid=%b result=%h busy=%b start_ready=%b, required 0/0/0/0",
                     res_valid, result, busy, start_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: start_ready=%b, required 1", start_ready);
        end
    endtask

    task automatic test_directed();
        logic [63:0] r; int lat, ac; bit to; exp_t e;
        res_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            sb.push_back('{VR[v], VL[v]});
            issue(VA[v], VB[v], VE[v], VI[v], 1'b1, r, lat, ac, to);
            e = sb.pop_front();
            checks++;
            if (to || r !== e.res) begin
                failures++;
                $display("FAIL directed%0d_result: got %h timeout=%0d, required %h", v, r, to, e.res);
            end
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL directed%0d_latency: got %0d, required %0d", v, lat, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] r; int lat, ac; bit to; exp_t e; bit bad;
        res_ready = 1'b0;
        sb.push_back(model(32'h00000005, 32'h00000021, 1'b0, 64'd0));
        issue(32'h00000005, 32'h00000021, 1'b0, 64'd0, 1'b0, r, lat, ac, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e.res || lat !== e.lat) begin
            failures++;
            $display("FAIL bp_result: got %h lat=%0d to=%0d, required %h lat=%0d", r, lat, to, e.res, e.lat);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            op_a = $urandom;
            op_b = $urandom;
            if (res_valid !== 1'b1 || result !== e.res || start_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold: res_valid=%b result=%h start_ready=%b busy=%b, required 1/%h/0/1",
                     res_valid, result, start_ready, busy, e.res);
        end
        @(negedge clk);
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: res_valid=%b busy=%b start_ready=%b, required 0/0/1",
                     res_valid, busy, start_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_second_accept: busy=%b res_valid=%b, required 0/0", busy, res_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] r; int lat, ac; bit to; exp_t e; bit seen;
        res_ready = 1'b1;
        @(negedge clk);
        op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; acc_en = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || result !== 64'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: res_valid=%b result=%h busy=%b, required 0/0/0", res_valid, result, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: start_ready=%b, required 1", start_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_result: activity seen after abort, required none");
        end
        sb.push_back('{64'h000000000000003F, 1});
        issue(32'd7, 32'd9, 1'b0, 64'd0, 1'b1, r, lat, ac, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e.res || lat !== e.lat) begin
            failures++;
            $display("FAIL abort_followup: got %h lat=%0d to=%0d, required %h lat=%0d", r, lat, to, e.res, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; int lat, ac, prev_ac, prev_lat; bit to; exp_t e;
        logic [31:0] a, b; logic en; logic [63:0] ai; int n;
        res_ready = 1'b1;
        prev_ac = 0; prev_lat = 0;
        for (int i = 0; i < 16; i++) begin
            n  = $urandom_range(0, 8);
            a  = $urandom;
            b  = $urandom & 32'((64'd1 << (4 * n)) - 64'd1);
            en = 1'($urandom_range(0, 1));
            ai = {$urandom, $urandom};
            sb.push_back(model(a, b, en, ai));
            issue(a, b, en, ai, 1'b1, r, lat, ac, to);
            e = sb.pop_front();
            checks++;
            if (to || r !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL b2b%0d: a=%h b=%h en=%0d got %h lat=%0d to=%0d, required %h lat=%0d",
                         i, a, b, en, r, lat, to, e.res, e.lat);
            end
            if (i > 0) begin
                checks++;
                if (ac - prev_ac !== prev_lat + 2) begin
                    failures++;
                    $display("FAIL b2b%0d_interval: got %0d cycles, required %0d", i, ac - prev_ac, prev_lat + 2);
                end
            end
            prev_ac = ac;
            prev_lat = e.lat;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_radix16_sequencer.md
# mul_radix16_sequencer

Multi-cycle unsigned 32×32→64 multiply(-accumulate) engine for the execute-stage multiply path. Retires one 4-bit digit of the multiplier per cycle, accumulating 36-bit digit partial products into a 64-bit running sum. Exits early once the remaining multiplier digits are zero. Takes operands from decode/issue over a valid/ready handshake and delivers a 64-bit product (UMULL/UMLAL style) to writeback over a second valid/ready handshake.

## Interface
- W, 32, operand width; only 32 is supported and verified.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operands and mode presented.
- start_ready  out  1  engine idle.
  - Combinational: high iff state is IDLE and rst is low.
- op_a  in  32  multiplicand; sampled only on the start handshake.
- op_b  in  32  multiplier; sampled only on the start handshake.
- acc_en  in  1  accumulate mode; sampled only on the start handshake.
- acc_in  in  64  addend used when acc_en=1; sampled only on the start handshake.
- res_valid  out  1  result available; registered.
- res_ready  in  1  consumer accepts result.
- result  out  64  product (+acc_in), modulo 2^64; registered.
- busy  out  1  high in CALC or DONE; registered.

## Operation
- **State machine:** IDLE, CALC, DONE.
- **IDLE → CALC** on `start_valid && start_ready` at a rising edge:
  - latch `a=op_a` and `b=op_b`;
  - set `acc = acc_en ? acc_in : 64'd0`;
  - set `cnt = 0` (3 bits).
- **CALC, each cycle:**
  - `acc <= acc + ((a * b[3:0]) << 4*cnt)`, truncated to 64 bits;
  - `b <= b >> 4`;
  - `cnt <= cnt + 1`.
  - The partial product is 36 bits wide; its maximum shift is 28, so it fits in 64 bits.
- **CALC → DONE** at the end of the cycle in which `(b >> 4) == 0` or `cnt == 7`.
  - CALC always executes at least one cycle, including when op_b=0.
  - On this transition, `result <= updated acc` and `res_valid <= 1`.
- **DONE → IDLE** on `res_valid && res_ready`. At that edge, `res_valid <= 0`.
  - `result` holds its value until the next DONE load; it is not cleared.
- **No overlap:** start_ready is low in CALC and DONE. start_valid is ignored outside IDLE, and op_* may change freely there.
- **Arithmetic:** unsigned only. Accumulation wraps modulo 2^64; the carry-out is discarded with no flag.
- **Reset:**
  - `state=IDLE`, `res_valid=0`, `result=0`, `busy=0`, `acc=0`, `cnt=0`.
  - start_ready is low while rst=1 and high the first cycle after.
- **Reset mid-operation:** the operation is abandoned with no partial result and no res_valid pulse. Reset dominates a simultaneous start or result handshake.

## Timing
- Let k = max(1, 1 + index of the highest nonzero nibble of op_b). Range is 1..8.
- Start handshake at edge E0. CALC updates at edges E1..Ek. res_valid goes high after Ek.
- Latency is k cycles from accept to res_valid. Minimum 1 (op_b ≤ 0xF), maximum 8.
- With res_ready held high, the result handshake occurs at edge Ek+1. start_ready is high after Ek+1, so the next accept can happen at Ek+2.
- Throughput is one operation per k+2 cycles.
- Backpressure: in DONE with res_ready low, result and res_valid are held indefinitely and are stable every cycle.
- busy tracks the state register: high from after E0 until after the result handshake edge.

## Test plan
- **Full width, no accumulate:** op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, acc_en=0.
  - result=0xFFFFFFFE00000001; res_valid exactly 8 cycles after accept.
- **Early exit:** op_a=0x12345678, op_b=0x3.
  - result=0x00000000369D0368; res_valid 1 cycle after accept.
- **Mid-digit exit:** op_a=0x12345678, op_b=0x00010000.
  - result=0x0000123456780000; latency 5 cycles.
- **Accumulate with wrap:** op_a=op_b=0xFFFFFFFF, acc_en=1, acc_in=0xFFFFFFFFFFFFFFFF.
  - result=0xFFFFFFFE00000000.
- **Zero multiplier:** op_b=0, acc_en=1, acc_in=0x0123456789ABCDEF.
  - result=0x0123456789ABCDEF after 1 cycle.
- **Backpressure and reset:**
  - Hold res_ready low 5 cycles while pulsing start_valid: result stable, start_ready=0, no second accept.
  - Separately, assert rst at the third CALC cycle: next cycle res_valid=0, result=0, busy=0, start_ready=1. No result is ever delivered for the aborted operation, and a following op_a=7, op_b=9 yields 63 (0x3F).
